// File: rtl/ram_stream_reader.sv
// Burst read engine: issues sequential RAM reads, buffers returns, streams them out with last marker.
// Credits (fifo_count + in_flight) cap outstanding reads so any RAM latency or backpressure is safe.
module ram_stream_reader #(
    parameter int D_WIDTH    = 32,
    parameter int A_WIDTH    = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A_WIDTH-1:0] base_addr,
    input  logic [A_WIDTH:0]   count,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               read_en,
    output logic [A_WIDTH-1:0] read_addr,
    input  logic [D_WIDTH-1:0] read_data,
    input  logic               read_valid,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t             state;
    logic [A_WIDTH-1:0] base_r;
    logic [A_WIDTH:0]   cnt_r;
    logic [A_WIDTH:0]   issued;
    logic [A_WIDTH:0]   received;
    logic [A_WIDTH:0]   popped;
    logic [CW-1:0]      in_flight;
    logic [CW-1:0]      fifo_count;
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic               err_r;
    logic [D_WIDTH-1:0] mem [FIFO_DEPTH];

    logic credit_ok;
    logic fifo_full;
    logic pop;
    logic push;
    logic bad_ret;
    logic ret_ok;

    // Reserve a FIFO slot for every read still in the RAM pipeline.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, in_flight}) < (CW+1)'(FIFO_DEPTH);
    assign read_en   = (state == S_RUN) && (issued < cnt_r) && credit_ok;
    assign read_addr = base_r + issued[A_WIDTH-1:0];

    assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign ret_ok    = read_valid && (in_flight != '0);
    assign bad_ret   = read_valid && ((in_flight == '0) || (fifo_full && !pop));
    assign push      = read_valid && !bad_ret;

    assign out_data = out_valid ? mem[rptr] : '0;
    assign out_last = out_valid && (popped == (cnt_r - (A_WIDTH+1)'(1)));
    assign busy     = (state == S_RUN) || (state == S_DRAIN);
    assign done     = (state == S_FIN);
    assign err      = err_r;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            base_r     <= '0;
            cnt_r      <= '0;
            issued     <= '0;
            received   <= '0;
            popped     <= '0;
            in_flight  <= '0;
            fifo_count <= '0;
            wptr       <= '0;
            rptr       <= '0;
            err_r      <= 1'b0;
        end else begin
            if (bad_ret) begin
                err_r <= 1'b1;
            end

            if (read_en && !ret_ok) begin
                in_flight <= in_flight + CW'(1);
            end else if (!read_en && ret_ok) begin
                in_flight <= in_flight - CW'(1);
            end

            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CW'(1);
            end

            if (push) begin
                wptr     <= wptr + PW'(1);
                received <= received + (A_WIDTH+1)'(1);
            end
            if (pop) begin
                rptr   <= rptr + PW'(1);
                popped <= popped + (A_WIDTH+1)'(1);
            end
            if (read_en) begin
                issued <= issued + (A_WIDTH+1)'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_r   <= base_addr;
                        cnt_r    <= count;
                        issued   <= '0;
                        received <= '0;
                        popped   <= '0;
                        state    <= (count == '0) ? S_FIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (issued == cnt_r) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((received == cnt_r) && pop && out_last) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a latency-programmable RAM model (mem[a] = a*3).
module tb_ram_stream_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  base_addr = '0;
    logic [5:0]  count = '0;
    logic        busy, done, err, read_en, out_valid, out_last;
    logic [4:0]  read_addr;
    logic [31:0] read_data, out_data;
    logic        read_valid;
    logic        out_ready = 1'b0;
    logic        inj_v = 1'b0;
    logic [31:0] inj_d = '0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;
    int lat = 1;

    ram_stream_reader #(.D_WIDTH(32), .A_WIDTH(5), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .err(err), .read_en(read_en), .read_addr(read_addr),
        .read_data(read_data), .read_valid(read_valid), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM read pipeline, reset together with the DUT
    logic       pv [3];
    logic [4:0] pa [3];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= '0;
            end
        end else begin
            pv[0] <= read_en;
            pa[0] <= read_addr;
            pv[1] <= pv[0];
            pa[1] <= pa[0];
            pv[2] <= pv[1];
            pa[2] <= pa[1];
        end
    end
    assign read_valid = pv[lat-1] | inj_v;
    assign read_data  = inj_v ? inj_d : ({27'd0, pa[lat-1]} * 32'd3);

    logic [4:0]  ra_q [$];
    int          rc_q [$];
    logic [31:0] od_q [$];
    logic        ol_q [$];
    int          oc_q [$];
    int          dc_q [$];
    bit          busy_seen = 1'b0;

    always @(negedge clk) begin
        if (read_en) begin
            ra_q.push_back(read_addr);
            rc_q.push_back(cyc - t0);
        end
        if (out_valid && out_ready) begin
            od_q.push_back(out_data);
            ol_q.push_back(out_last);
            oc_q.push_back(cyc - t0);
        end
        if (done) dc_q.push_back(cyc - t0);
        if (busy) busy_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        ra_q.delete(); rc_q.delete(); od_q.delete();
        ol_q.delete(); oc_q.delete(); dc_q.delete();
        busy_seen = 1'b0;
    endtask

    task automatic go(input logic [4:0] b, input logic [5:0] c);
        start = 1'b1;
        base_addr = b;
        count = c;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        tests++;
        if ({busy, done, err, read_en, out_valid, out_last} !== 6'b0) begin
            fails++; $display("FAIL reset_flags got %b want 000000", {busy, done, err, read_en, out_valid, out_last});
        end
        tests++;
        if (read_addr !== 5'd0) begin fails++; $display("FAIL reset_addr got %0d want 0", read_addr); end
        tests++;
        if (out_data !== 32'd0) begin fails++; $display("FAIL reset_data got %0d want 0", out_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n = 0;
        lat = 1; out_ready = 1'b1;
        clear_mon();
        go(5'd4, 6'd6);
        while (dc_q.size() == 0 && n < 40) begin tick(); n++; end
        repeat (3) tick();
        tests++;
        if (ra_q.size() != 6) begin fails++; $display("FAIL basic_nreads got %0d want 6", ra_q.size()); end
        for (int i = 0; i < 6 && i < ra_q.size(); i++) begin
            tests++;
            if (ra_q[i] !== 5'(4 + i) || rc_q[i] != 1 + i) begin
                fails++; $display("FAIL basic_read[%0d] got addr %0d cyc %0d want addr %0d cyc %0d", i, ra_q[i], rc_q[i], 4 + i, 1 + i);
            end
        end
        tests++;
        if (od_q.size() != 6) begin fails++; $display("FAIL basic_nwords got %0d want 6", od_q.size()); end
        for (int i = 0; i < 6 && i < od_q.size(); i++) begin
            tests++;
            if (od_q[i] !== 32'((4 + i) * 3) || oc_q[i] != 3 + i || ol_q[i] !== (i == 5)) begin
                fails++; $display("FAIL basic_word[%0d] got %0d cyc %0d last %0d want %0d cyc %0d last %0d",
                                  i, od_q[i], oc_q[i], ol_q[i], (4 + i) * 3, 3 + i, (i == 5));
            end
        end
        tests++;
        if (dc_q.size() != 1 || dc_q[0] != 9) begin
            fails++; $display("FAIL basic_done got %0d pulses first at %0d want 1 at 9", dc_q.size(), (dc_q.size() > 0) ? dc_q[0] : -1);
        end
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL basic_err got %0d want 0", err); end
    endtask

    task automatic test_wrap();
        int n = 0;
        int exp_a [4] = '{30, 31, 0, 1};
        lat = 1; out_ready = 1'b1;
        clear_mon();
        go(5'd30, 6'd4);
        while (dc_q.size() == 0 && n < 40) begin tick(); n++; end
        repeat (2) tick();
        tests++;
        if (ra_q.size() != 4 || od_q.size() != 4) begin
            fails++; $display("FAIL wrap_sizes got %0d reads %0d words want 4 4", ra_q.size(), od_q.size());
        end
        for (int i = 0; i < 4 && i < ra_q.size() && i < od_q.size(); i++) begin
            tests++;
            if (ra_q[i] !== 5'(exp_a[i]) || od_q[i] !== 32'(exp_a[i] * 3)) begin
                fails++; $display("FAIL wrap[%0d] got addr %0d data %0d want addr %0d data %0d", i, ra_q[i], od_q[i], exp_a[i], exp_a[i] * 3);
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        lat = 3; out_ready = 1'b0;
        clear_mon();
        go(5'd1, 6'd10);
        repeat (20) tick();
        tests++;
        if (ra_q.size() != 4) begin fails++; $display("FAIL bp_credit_reads got %0d want 4", ra_q.size()); end
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'd3 || busy !== 1'b1) begin
            fails++; $display("FAIL bp_hold got valid %0d data %0d busy %0d want 1 3 1", out_valid, out_data, busy);
        end
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL bp_err_full got %0d want 0", err); end
        out_ready = 1'b1;
        while (dc_q.size() == 0 && n < 100) begin tick(); n++; end
        repeat (3) tick();
        tests++;
        if (od_q.size() != 10 || ra_q.size() != 10) begin
            fails++; $display("FAIL bp_counts got %0d words %0d reads want 10 10", od_q.size(), ra_q.size());
        end
        for (int i = 0; i < 10 && i < od_q.size(); i++) begin
            tests++;
            if (od_q[i] !== 32'((1 + i) * 3) || ol_q[i] !== (i == 9)) begin
                fails++; $display("FAIL bp_word[%0d] got %0d last %0d want %0d last %0d", i, od_q[i], ol_q[i], (1 + i) * 3, (i == 9));
            end
        end
        tests++;
        if (dc_q.size() != 1 || err !== 1'b0) begin
            fails++; $display("FAIL bp_done got %0d pulses err %0d want 1 0", dc_q.size(), err);
        end
        lat = 1;
    endtask

    task automatic test_zero_count();
        out_ready = 1'b1;
        clear_mon();
        go(5'd7, 6'd0);
        repeat (6) tick();
        tests++;
        if (ra_q.size() != 0) begin fails++; $display("FAIL zero_reads got %0d want 0", ra_q.size()); end
        tests++;
        if (dc_q.size() != 1 || dc_q[0] < 1 || dc_q[0] > 2) begin
            fails++; $display("FAIL zero_done got %0d pulses first at %0d want 1 at 1..2", dc_q.size(), (dc_q.size() > 0) ? dc_q[0] : -1);
        end
        tests++;
        if (busy_seen !== 1'b0) begin fails++; $display("FAIL zero_busy got %0d want 0", busy_seen); end
    endtask

    task automatic test_start_while_busy();
        int n = 0;
        lat = 1; out_ready = 1'b1;
        clear_mon();
        go(5'd4, 6'd6);
        tick();
        start = 1'b1; base_addr = 5'd20; count = 6'd3;
        tick();
        start = 1'b0;
        while (dc_q.size() == 0 && n < 40) begin tick(); n++; end
        repeat (5) tick();
        tests++;
        if (ra_q.size() != 6 || od_q.size() != 6 || dc_q.size() != 1) begin
            fails++; $display("FAIL busy_start_counts got %0d reads %0d words %0d done want 6 6 1", ra_q.size(), od_q.size(), dc_q.size());
        end
        for (int i = 0; i < 6 && i < ra_q.size() && i < od_q.size(); i++) begin
            tests++;
            if (ra_q[i] !== 5'(4 + i) || od_q[i] !== 32'((4 + i) * 3)) begin
                fails++; $display("FAIL busy_start[%0d] got addr %0d data %0d want %0d %0d", i, ra_q[i], od_q[i], 4 + i, (4 + i) * 3);
            end
        end
    endtask

    task automatic test_reset_err();
        int n = 0;
        lat = 2; out_ready = 1'b1;
        clear_mon();
        go(5'd0, 6'd8);
        while (ra_q.size() < 3 && n < 20) begin tick(); n++; end
        tests++;
        if (ra_q.size() < 3) begin fails++; $display("FAIL rst_mid_wait got %0d reads want 3", ra_q.size()); end
        rst = 1'b1;
        tick();
        tests++;
        if ({busy, done, err, read_en, out_valid, out_last} !== 6'b0 || out_data !== 32'd0) begin
            fails++; $display("FAIL rst_mid_outputs got %b data %0d want 000000 0", {busy, done, err, read_en, out_valid, out_last}, out_data);
        end
        rst = 1'b0;
        clear_mon();
        repeat (4) tick();
        tests++;
        if (ra_q.size() != 0 || err !== 1'b0) begin
            fails++; $display("FAIL rst_mid_quiet got %0d reads err %0d want 0 0", ra_q.size(), err);
        end
        inj_v = 1'b1; inj_d = 32'hDEAD_BEEF;
        tick();
        inj_v = 1'b0;
        tests++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL late_return got err %0d valid %0d want 1 0", err, out_valid);
        end
        repeat (5) tick();
        tests++;
        if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got %0d want 1", err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL err_clear got %0d want 0", err); end
        lat = 1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_count();
        test_start_while_busy();
        test_reset_err();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
